// File: rtl/mips_pkg.sv
// Shared MIPS decode/write-back definitions: default widths, the hardwired
// zero register address and the register address/data types.
package mips_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/register_word.sv
// One register-file word: a bank of enable-gated D flops with an
// asynchronous active-low clear.
module register_word #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] q_q;

  // Load on enable, clear immediately when reset falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/register_file.sv
// MIPS general-purpose register file: two combinational read ports, one
// clocked write port, $0 hardwired to zero.
// Optional feature: define REGFILE_BYPASS_EN for write-through bypass of a
// same-cycle write onto the read ports (resolves the WB-to-ID hazard).
module register_file
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] words [NumRegs];

  // Word 0 has no storage.
  assign words[0] = '0;

  for (genvar i = 1; i < NumRegs; i++) begin : g_word
    logic word_en;

    // One-hot decode of the write address gated by the write enable.
    assign word_en = we && (wa == ADDR_WIDTH'(i));

    register_word #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_word (
      .clk(clk),
      .rst(rst),
      .en (word_en),
      .d  (wd),
      .q  (words[i])
    );
  end

`ifdef REGFILE_BYPASS_EN
  localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(REG_ZERO);

  logic bypass_ok;

  // Bypass only for a real write: out of reset, enabled, nonzero target.
  assign bypass_ok = rst && we && (wa != ZeroAddr);

  // Read port 1: stored word, or write data when it targets the same register.
  always_comb begin
    rd1 = words[ra1];
    if (bypass_ok && (ra1 == wa)) begin
      rd1 = wd;
    end
  end

  // Read port 2: stored word, or write data when it targets the same register.
  always_comb begin
    rd2 = words[ra2];
    if (bypass_ok && (ra2 == wa)) begin
      rd2 = wd;
    end
  end
`else
  // Read port 1: stored word; a same-cycle write shows up after the edge.
  always_comb begin
    rd1 = words[ra1];
  end

  // Read port 2: stored word; a same-cycle write shows up after the edge.
  always_comb begin
    rd2 = words[ra2];
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read data,
// a monitor pops and compares on each sample strobe.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .we (we),
    .wa (wa),
    .wd (wd),
    .ra1(ra1),
    .ra2(ra2),
    .rd1(rd1),
    .rd2(rd2)
  );

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        sb[$];
  logic        sample;
  logic [31:0] mdl [32];
  int          n_checks;
  int          n_fail;

  // Posedges at 50, 150, ...; negedges at 100, 200, ...
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Monitor: compare read ports against every queued expectation.
  initial begin
    exp_t it;
    forever begin
      @(posedge sample);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        n_checks++;
        if (rd1 !== it.e1 || rd2 !== it.e2) begin
          n_fail++;
          $display("FAIL %s: got rd1=%h rd2=%h, expected rd1=%h rd2=%h (ra1=%0d ra2=%0d)",
                   it.name, rd1, rd2, it.e1, it.e2, ra1, ra2);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] e1, input logic [31:0] e2);
    exp_t it;
    ra1 = a1;
    ra2 = a2;
    #1;
    it.name = nm;
    it.e1   = e1;
    it.e2   = e2;
    sb.push_back(it);
    sample = 1'b1;
    #1;
    sample = 1'b0;
  endtask

  task automatic chk_mdl(input string nm, input logic [4:0] a1, input logic [4:0] a2);
    chk(nm, a1, a2, mdl[a1], mdl[a2]);
  endtask

  // Write one register across one rising edge; model follows after the edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    wa = a;
    wd = d;
    @(negedge clk);
    we = 1'b0;
    if (a != 5'd0) mdl[a] = d;
  endtask

  task automatic sweep(input string nm);
    for (int i = 0; i < 32; i++) begin
      chk_mdl(nm, 5'(i), 5'(31 - i));
    end
  endtask

  initial begin
    logic [31:0] hz_exp;
    n_checks = 0;
    n_fail   = 0;
    sample   = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

    // Reset held with a live write request: must be ignored.
    rst = 1'b0;
    we  = 1'b1;
    wa  = 5'd5;
    wd  = 32'hDEADBEEF;
    ra1 = 5'd5;
    ra2 = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", 5'd5, 5'd5, 32'h0, 32'h0);
    @(negedge clk);
    we  = 1'b0;
    rst = 1'b1;
    chk("reset_release", 5'd5, 5'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    sweep("reset_sweep");

    // Basic write then read on both ports.
    wr(5'd8, 32'h12345678);
    wr(5'd31, 32'hCAFEF00D);
    chk("wr_rd_r8_r31", 5'd8, 5'd31, 32'h12345678, 32'hCAFEF00D);
    chk("wr_rd_swap", 5'd31, 5'd8, 32'hCAFEF00D, 32'h12345678);
    chk("same_addr", 5'd8, 5'd8, 32'h12345678, 32'h12345678);

    // $0 writes are discarded, even with bypass enabled.
    chk("r0_before", 5'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    we = 1'b1;
    wa = 5'd0;
    wd = 32'hFFFFFFFF;
    chk("r0_during", 5'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    we = 1'b0;
    chk("r0_after", 5'd0, 5'd8, 32'h0, 32'h12345678);

    // Same-cycle write/read hazard on r9.
    wr(5'd9, 32'h1);
`ifdef REGFILE_BYPASS_EN
    hz_exp = 32'h2;
`else
    hz_exp = 32'h1;
`endif
    @(negedge clk);
    we = 1'b1;
    wa = 5'd9;
    wd = 32'h2;
    chk("hazard_before", 5'd9, 5'd8, hz_exp, 32'h12345678);
    @(negedge clk);
    we = 1'b0;
    mdl[9] = 32'h2;
    chk("hazard_after", 5'd9, 5'd9, 32'h2, 32'h2);

    // Back-to-back writes: last edge wins.
    @(negedge clk);
    we = 1'b1;
    wa = 5'd12;
    wd = 32'hAAAA0001;
    @(negedge clk);
    wd = 32'hBBBB0002;
    @(negedge clk);
    we = 1'b0;
    mdl[12] = 32'hBBBB0002;
    chk_mdl("back_to_back", 5'd12, 5'd9);

    // Fill r1..r31 with own index, then pulse reset between edges.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    sweep("fill_index");
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 1; i < 17; i++) begin
      chk("midrun_reset", 5'(i), 5'(i + 15), 32'h0, 32'h0);
    end
    rst = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    @(posedge clk);
    #1;
    sweep("post_reset_sweep");

    // Refill with distinct patterns, then hold we=0 with random wa/wd.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101 ^ 32'h5A5A0000);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      we = 1'b0;
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      chk_mdl("we0_random", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    @(posedge clk);
    #1;
    sweep("we0_sweep");

    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
